// File: rtl/count_uart_tx_if.sv
// count_uart_tx_if: valid/ready word handshake feeding the UART transmitter.
// The master drives the word and valid.
// The slave (the transmitter) answers with ready.
`timescale 1ns/1ps

interface count_uart_tx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/count_uart_tx.sv
// count_uart_tx: serialises 8-bit counter values onto an 8N1 UART line.
// Bits go out LSB first, with CLKS_PER_BIT clocks per bit.
// A single holding register decouples the producer from the shifter.
// Optional build macro: COUNT_TX_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit, giving 11-bit frames.
`timescale 1ns/1ps

module count_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  count_uart_tx_if.slave       bus,
  output logic                 tx,
  output logic                 busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef COUNT_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic [7:0]       hold_data;
  logic             hold_full;
`ifdef COUNT_TX_PARITY_EN
  logic             parity_bit;
`endif

  logic baud_last;
  logic accept;
  logic load;

  // Handshake and status are derived only from registered state, never from in_valid
  always_comb begin
    bus.in_ready = ena & ~hold_full;
    busy         = (state != IDLE) | hold_full;
    baud_last    = (baud_cnt == CNT_LAST);
    accept       = bus.in_valid & ena & ~hold_full;
    load         = hold_full & ((state == IDLE) | ((state == STOP) & baud_last));
  end

  // Holding register, frame FSM, baud/bit counters and the registered tx line; ena=0 freezes all of it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= 3'd0;
      shift_reg  <= 8'd0;
      hold_data  <= 8'd0;
      hold_full  <= 1'b0;
      tx         <= 1'b1;
`ifdef COUNT_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (ena) begin
      if (accept) begin
        hold_data <= bus.in_data;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end

      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= 3'd0;
          if (hold_full) begin
            state      <= START;
            shift_reg  <= hold_data;
            tx         <= 1'b0;
`ifdef COUNT_TX_PARITY_EN
            parity_bit <= ^hold_data;
`endif
          end
        end

        START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            state    <= DATA;
            tx       <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= 3'd0;
`ifdef COUNT_TX_PARITY_EN
              state   <= PARITY;
              tx      <= parity_bit;
`else
              state   <= STOP;
              tx      <= 1'b1;
`endif
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              shift_reg <= {1'b0, shift_reg[7:1]};
              tx        <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

`ifdef COUNT_TX_PARITY_EN
        PARITY: begin
          if (baud_last) begin
            baud_cnt <= '0;
            state    <= STOP;
            tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (hold_full) begin
              state      <= START;
              shift_reg  <= hold_data;
              tx         <= 1'b0;
`ifdef COUNT_TX_PARITY_EN
              parity_bit <= ^hold_data;
`endif
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          bit_idx  <= 3'd0;
          tx       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_uart_tx.sv
// tb_count_uart_tx: self-checking bench for count_uart_tx with CLKS_PER_BIT=4.
// A UART receiver model decodes tx and checks each frame against a scoreboard.
// The receiver counts only cycles in which ena was high.
// Each accepted word pushes its expected byte and parity onto the scoreboard.
// Honours COUNT_TX_PARITY_EN, which gives 11-bit frames.
`timescale 1ns/1ps

module tb_count_uart_tx;

  localparam int CPB = 4;
`ifdef COUNT_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * CPB;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic ena   = 1'b1;
  logic tx;
  logic busy;

  count_uart_tx_if bus_if ();

  count_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus_if),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] in_data;
    logic [7:0] exp_byte;
    logic       exp_par;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];
  int   start_q[$];
  bit   in_frame = 1'b0;
  logic ena_q    = 1'b1;
  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one word and hold it until the handshake takes it; returns 1ns after the accepting edge
  task automatic applyStimulus(input logic [7:0] data, input logic [7:0] exp_byte,
                               input logic exp_par, output int waited);
    bit ok;
    ok     = 1'b0;
    waited = 0;
    bus_if.in_data  = data;
    bus_if.in_valid = 1'b1;
    while (!ok && waited < 200) begin
      if (bus_if.in_ready === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        waited++;
      end
    end
    #1;
    bus_if.in_valid = 1'b0;
    checkOutput("accept_in_time", {31'd0, ok}, 32'd1);
    if (ok) begin
      sb_q.push_back('{data: exp_byte, par: exp_par});
      checkOutput("ready_low_after_accept", {31'd0, bus_if.in_ready}, 32'd0);
    end
  endtask

  task automatic waitDrain(input int bound);
    int n;
    bit timed_out;
    n = 0;
    timed_out = 1'b0;
    while (!(busy === 1'b0 && sb_q.size() == 0 && !in_frame) && !timed_out) begin
      @(posedge clk);
      #1;
      n++;
      if (n > bound) timed_out = 1'b1;
    end
    checkOutput("drain_done", {31'd0, timed_out}, 32'd0);
    if (timed_out) sb_q.delete();
  endtask

  task automatic frameDone(input logic [10:0] bits);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL unexpected_frame: got byte 0x%0h expected no frame", bits[8:1]);
    end else begin
      e = sb_q.pop_front();
      checkOutput("start_bit", {31'd0, bits[0]}, 32'd0);
      checkOutput("rx_byte", {24'd0, bits[8:1]}, {24'd0, e.data});
`ifdef COUNT_TX_PARITY_EN
      checkOutput("parity_bit", {31'd0, bits[9]}, {31'd0, e.par});
`endif
      checkOutput("stop_bit", {31'd0, bits[NBITS-1]}, 32'd1);
    end
  endtask

  // Capture the ena value that each rising edge actually sees
  initial begin
    forever begin
      @(posedge clk);
      ena_q = ena;
    end
  end

  // UART receiver model: samples mid-bit on effective (ena-high) cycles
  initial begin
    int cyc;
    int nb;
    int eff;
    logic [10:0] bits;
    logic prev_tx;
    cyc = 0;
    nb = 0;
    eff = 0;
    bits = '0;
    prev_tx = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 1'b0;
      end else begin
        if (ena_q) eff++;
        if (!in_frame) begin
          if (tx === 1'b0) begin
            in_frame = 1'b1;
            cyc = 0;
            nb = 0;
            start_q.push_back(eff);
          end
        end else if (ena_q) begin
          cyc++;
          if (cyc % CPB == CPB / 2) begin
            bits[nb] = tx;
            nb++;
            if (nb == NBITS) begin
              frameDone(bits);
              in_frame = 1'b0;
            end
          end
        end else begin
          checkOutput("tx_frozen", {31'd0, tx}, {31'd0, prev_tx});
        end
      end
      prev_tx = tx;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    int base;
    logic txlog[1:60];
    logic [7:0] pat;

    vecs[0] = '{in_data: 8'h00, exp_byte: 8'h00, exp_par: 1'b0};
    vecs[1] = '{in_data: 8'hFF, exp_byte: 8'hFF, exp_par: 1'b0};
    vecs[2] = '{in_data: 8'h01, exp_byte: 8'h01, exp_par: 1'b1};
    vecs[3] = '{in_data: 8'hC5, exp_byte: 8'hC5, exp_par: 1'b0};
    vecs[4] = '{in_data: 8'h07, exp_byte: 8'h07, exp_par: 1'b1};
    vecs[5] = '{in_data: 8'h5A, exp_byte: 8'h5A, exp_par: 1'b0};
    vecs[6] = '{in_data: 8'hA3, exp_byte: 8'hA3, exp_par: 1'b0};

    bus_if.in_data  = 8'h00;
    bus_if.in_valid = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    #12;
    checkOutput("reset_tx", {31'd0, tx}, 32'd1);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checkOutput("ready_after_reset", {31'd0, bus_if.in_ready}, 32'd1);

    // Single word: start latency and busy release timing
    @(posedge clk);
    #1;
    applyStimulus(8'hC5, 8'hC5, 1'b0, waited);
    checkOutput("busy_after_accept", {31'd0, busy}, 32'd1);
    checkOutput("tx_idle_at_accept", {31'd0, tx}, 32'd1);
    for (int k = 1; k <= FRAME_CYC + 1; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) checkOutput("start_latency", {31'd0, tx}, 32'd0);
      if (k == FRAME_CYC) checkOutput("busy_last_stop", {31'd0, busy}, 32'd1);
      if (k == FRAME_CYC + 1) checkOutput("busy_release", {31'd0, busy}, 32'd0);
    end
    waitDrain(100);

    // Table-driven back-to-back frames with no idle gaps
    base = start_q.size();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].in_data, vecs[i].exp_byte, vecs[i].exp_par, waited);
    end
    waitDrain(FRAME_CYC * 4);
    checkOutput("b2b_frame_count", start_q.size() - base, 32'd7);
    for (int j = base + 1; j < start_q.size(); j++) begin
      checkOutput("b2b_frame_gap", start_q[j] - start_q[j-1], FRAME_CYC);
    end

    // Backpressure: third word waits while the holding register is full
    @(posedge clk);
    #1;
    applyStimulus(8'h11, 8'h11, 1'b0, waited);
    applyStimulus(8'h22, 8'h22, 1'b0, waited);
    checkOutput("ready_low_when_full", {31'd0, bus_if.in_ready}, 32'd0);
    applyStimulus(8'h5A, 8'h5A, 1'b0, waited);
    checkOutput("backpressure_waited", {31'd0, waited > 0}, 32'd1);
    waitDrain(FRAME_CYC * 5);

    // ena freeze during data bit 3 of 0x96
    @(posedge clk);
    #1;
    applyStimulus(8'h96, 8'h96, 1'b0, waited);
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      txlog[k] = tx;
      if (k >= 19 && k <= 25) checkOutput("ready_low_in_freeze", {31'd0, bus_if.in_ready}, 32'd0);
      if (k == 18) ena = 1'b0;
      if (k == 25) ena = 1'b1;
    end
    pat = 8'h96;
    checkOutput("freeze_bit2", {31'd0, txlog[16]}, {31'd0, pat[2]});
    for (int k = 17; k <= 27; k++) begin
      checkOutput("freeze_bit3_held", {31'd0, txlog[k]}, {31'd0, pat[3]});
    end
    checkOutput("freeze_bit4", {31'd0, txlog[28]}, {31'd0, pat[4]});
    waitDrain(FRAME_CYC * 2);

    // Reset mid-frame aborts the frame and the pending word
    @(posedge clk);
    #1;
    applyStimulus(8'h77, 8'h77, 1'b0, waited);
    applyStimulus(8'h88, 8'h88, 1'b0, waited);
    repeat (12) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_tx", {31'd0, tx}, 32'd1);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    sb_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checkOutput("abort_ready", {31'd0, bus_if.in_ready}, 32'd1);
    checkOutput("abort_busy_release", {31'd0, busy}, 32'd0);
    checkOutput("abort_tx_release", {31'd0, tx}, 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(8'h3C, 8'h3C, 1'b0, waited);
    waitDrain(FRAME_CYC * 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
